// File: rtl/sdf_r2_stage_pkg.sv
// sdf_pkg: shared types and arithmetic helpers for the radix-2 SDF FFT stage.
//   state_t  : stage FSM states
//   wide_t   : 64-bit signed working type; all butterfly math is done here
//              and narrowed to WIDTH bits by the caller after saturation
//   sat_w    : clamp to the signed range of a w-bit word
//   rnd_half : halve with round-half-up, (x+1)>>>1
//   neg_sat  : negate and clamp (-(-2^(w-1)) becomes 2^(w-1)-1)
package sdf_pkg;

   typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

   typedef logic signed [63:0] wide_t;

   function automatic wide_t sat_w(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic wide_t rnd_half(input wide_t x);
      return (x + wide_t'(1)) >>> 1;
   endfunction

   function automatic wide_t neg_sat(input wide_t x, input int w);
      return sat_w(-x, w);
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: enabled shift register, DEPTH entries of 2*WIDTH bits.
//   clock : master clock
//   en    : shift one position (write din, advance all entries)
//   din   : {re, im} written at the head
//   dout  : {re, im} at the tail (oldest entry)
// No reset: the stage FSM never emits an entry it has not written.
module sdf_delay_line
   import sdf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                 clock,
   input  logic                 en,
   input  logic [2*WIDTH-1:0]   din,
   output logic [2*WIDTH-1:0]   dout
);

   logic [DEPTH-1:0][2*WIDTH-1:0] mem;

   always_ff @(posedge clock) begin
      if (en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// sdf_r2_stage: radix-2 single-path delay-feedback FFT stage.
//   clock, reset   : master clock, synchronous active-high reset
//   di_en/re/im    : input sample, accepted when di_en & di_rdy
//   di_rdy         : low only while draining the last group's differences
//   do_en/re/im    : registered output sample (re/im hold when do_en=0)
//   do_sof         : first sample of each 2^LOG2_N output frame
// Per group of G=2D inputs: the first D are stored, the second D are
// combined with the stored ones; sums go out immediately, differences are
// stored and popped during the next group's fill (or during DRAIN).
module sdf_r2_stage
   import sdf_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LOG2_DEPTH = 3,
   parameter int LOG2_N     = 8,
   parameter int MJ_EN      = 1,
   parameter int SCALE      = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   output logic             di_rdy,
   output logic             do_en,
   output logic             do_sof,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im
);

   localparam int D  = 1 << LOG2_DEPTH;
   localparam int PW = LOG2_DEPTH + 1;

   state_t            state;
   logic [PW-1:0]     p;
   logic              pend;
   logic [LOG2_N-1:0] out_cnt;

   logic               acc;
   logic               adv;
   logic [2*WIDTH-1:0] dl_in;
   logic [2*WIDTH-1:0] dl_out;
   logic [WIDTH-1:0]   dl_re, dl_im;

   logic [WIDTH-1:0]   sum_re, sum_im, dif_re, dif_im;
   logic               emit;
   logic [WIDTH-1:0]   o_re, o_im;

   assign di_rdy = (state != DRAIN);
   assign acc    = di_en & di_rdy;
   assign adv    = acc | (state == DRAIN);

   // BFLY feeds the (possibly rotated) difference back; otherwise the input.
   assign dl_in = (state == BFLY) ? {dif_re, dif_im} : {di_re, di_im};
   assign dl_re = dl_out[2*WIDTH-1:WIDTH];
   assign dl_im = dl_out[WIDTH-1:0];

   sdf_delay_line #(.WIDTH(WIDTH), .DEPTH(D)) u_dl (
      .clock (clock),
      .en    (adv),
      .din   (dl_in),
      .dout  (dl_out)
   );

   function automatic wide_t fin(input wide_t x);
      wide_t s;
      s = (SCALE != 0) ? rnd_half(x) : x;
      return sat_w(s, WIDTH);
   endfunction

   // Butterfly: a = delay output, b = input. In BFLY the low bits of p are
   // the difference index d, so p[LOG2_DEPTH-1] marks d >= D/2 for -j.
   always_comb begin
      wide_t a_re, a_im, b_re, b_im, dr, di;
      a_re = wide_t'($signed(dl_re));
      a_im = wide_t'($signed(dl_im));
      b_re = wide_t'($signed(di_re));
      b_im = wide_t'($signed(di_im));
      sum_re = WIDTH'(fin(a_re + b_re));
      sum_im = WIDTH'(fin(a_im + b_im));
      dr = fin(a_re - b_re);
      di = fin(a_im - b_im);
      if (MJ_EN != 0 && p[LOG2_DEPTH-1]) begin
         dif_re = WIDTH'(di);
         dif_im = WIDTH'(neg_sat(dr, WIDTH));
      end else begin
         dif_re = WIDTH'(dr);
         dif_im = WIDTH'(di);
      end
   end

   always_comb begin
      emit = 1'b0;
      o_re = dl_re;
      o_im = dl_im;
      case (state)
         FILL:    emit = acc & pend;
         BFLY: begin
            emit = acc;
            o_re = sum_re;
            o_im = sum_im;
         end
         DRAIN:   emit = 1'b1;
         default: emit = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         p       <= '0;
         pend    <= 1'b0;
         out_cnt <= '0;
         do_en   <= 1'b0;
         do_sof  <= 1'b0;
         do_re   <= '0;
         do_im   <= '0;
      end else begin
         do_en  <= emit;
         do_sof <= emit && (out_cnt == '0);
         if (emit) begin
            out_cnt <= out_cnt + 1'b1;
            do_re   <= o_re;
            do_im   <= o_im;
         end
         case (state)
            IDLE: if (acc) begin
               p     <= PW'(1);
               state <= FILL;
            end
            FILL: begin
               if (acc) begin
                  p <= p + 1'b1;
                  if (p == PW'(D - 1)) state <= BFLY;
               end else if (pend && p == '0) begin
                  // Input gap right at a group boundary = end of stream.
                  state <= DRAIN;
               end
            end
            BFLY: if (acc) begin
               if (p == '1) begin
                  p     <= '0;
                  pend  <= 1'b1;
                  state <= FILL;
               end else begin
                  p <= p + 1'b1;
               end
            end
            DRAIN: begin
               if (p == PW'(D - 1)) begin
                  p     <= '0;
                  pend  <= 1'b0;
                  state <= IDLE;
               end else begin
                  p <= p + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
